// File: rtl/axi_upsizer.sv
// AXI-Stream width up-converter: packs RATIO DW-bit beats little-endian into one registered word; word appears 1 cycle after its completing beat.
// Backpressure: s_tready = ~m_tvalid | m_tready, so a stalled output word blocks all input acceptance.
module axi_upsizer #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DW*RATIO-1:0]   m_tdata,
  output logic [RATIO-1:0]      m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int IW = $clog2(RATIO);

  logic [IW-1:0]              idx;
  logic [RATIO-1:0][DW-1:0]   acc_data;
  logic [RATIO-1:0]           acc_keep;
  logic [RATIO-1:0][DW-1:0]   merged_data;
  logic [RATIO-1:0]           merged_keep;
  logic                       accept;
  logic                       completing;

  assign s_tready   = ~m_tvalid | m_tready;
  assign accept     = s_tvalid & s_tready;
  assign completing = accept & (s_tlast | (idx == IW'(RATIO - 1)));

  // Stale accumulator lanes are masked by keep, so unwritten lanes always read as zero.
  always_comb begin
    merged_data = '0;
    merged_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (acc_keep[i]) merged_data[i] = acc_data[i];
      if (IW'(i) == idx) begin
        merged_data[i] = s_tdata;
        merged_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      if (m_tvalid && m_tready && !completing) m_tvalid <= 1'b0;
      if (accept) begin
        if (completing) begin
          m_tdata  <= merged_data;
          m_tkeep  <= merged_keep;
          m_tlast  <= s_tlast;
          m_tvalid <= 1'b1;
          idx      <= '0;
          acc_keep <= '0;
        end else begin
          acc_data <= merged_data;
          acc_keep <= merged_keep;
          idx      <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_upsizer.sv
// Self-checking bench for axi_upsizer (DW=8, RATIO=4) with a byte-queue reference model.
module tb_axi_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  axi_upsizer #(.DW(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t      obs_q[$];
  word_t      exp_q[$];
  logic [7:0] cur[$];
  logic [7:0] sent_b[$];
  bit         sent_l[$];
  word_t      wm;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model: collect accepted bytes, emit a word at 4 bytes or on tlast.
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
    end else begin
      if (m_tvalid && m_tready) obs_q.push_back('{m_tdata, m_tkeep, m_tlast});
      if (s_tvalid && s_tready) begin
        cur.push_back(s_tdata);
        if (cur.size() == 4 || s_tlast) begin
          wm.data = 32'h0;
          for (int i = 0; i < cur.size(); i++) wm.data[8*i +: 8] = cur[i];
          wm.keep = 4'((1 << cur.size()) - 1);
          wm.last = s_tlast;
          exp_q.push_back(wm);
          cur.delete();
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit l, output int waits);
    bit acc;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1; waits = 0;
    acc = 1'b0;
    while (!acc && waits <= 200) begin
      @(negedge clk);
      acc = s_tready && !rst;
      @(posedge clk); #2;
      if (!acc) waits++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic flush();
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tkeep !== 4'h0 || m_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b, want 0", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_words();
    int w;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(8'(i + 1), 1'b0, w);
      n_checks++;
      if (w !== 0) begin n_fail++; $display("FAIL full_tready beat%0d: waited %0d cycles, want 0", i, w); end
      if (i == 2 || i == 6) begin
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL full_early beat%0d: m_tvalid=%b want 0", i, m_tvalid); end
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== ((i == 3) ? 32'h04030201 : 32'h08070605) ||
            m_tkeep !== 4'hF || m_tlast !== 1'b0) begin
          n_fail++;
          $display("FAIL full_word beat%0d: got v=%b d=%h k=%h l=%b", i, m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
      end
    end
    flush();
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL full_count: got %0d words want 2", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_early_last();
    int w;
    logic [7:0] pk[7];
    pk[0] = 8'hAA; pk[1] = 8'hBB; pk[2] = 8'hCC;
    pk[3] = 8'h11; pk[4] = 8'h22; pk[5] = 8'h33; pk[6] = 8'h44;
    m_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_beat(pk[i], i == 2, w);
      if (i == 2) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00CCBBAA || m_tkeep !== 4'h7 || m_tlast !== 1'b1) begin
          n_fail++;
          $display("FAIL early_word: got v=%b d=%h k=%h l=%b want 1/00ccbbaa/7/1", m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL early_consume: m_tvalid=%b want 0", m_tvalid); end
      end
      if (i == 6) begin
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h44332211 || m_tkeep !== 4'hF || m_tlast !== 1'b0) begin
          n_fail++;
          $display("FAIL early_next: got v=%b d=%h k=%h l=%b want 1/44332211/f/0", m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
      end
    end
    flush();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_beat();
    int w;
    m_tready = 1'b1;
    send_beat(8'h5A, 1'b1, w);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000005A || m_tkeep !== 4'h1 || m_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL single_word: got v=%b d=%h k=%h l=%b want 1/0000005a/1/1", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    flush();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    int w;
    bit bad;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'hD0 + 8'(i), 1'b0, w);
    s_tdata = 8'hE0; s_tvalid = 1'b1; s_tlast = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'hD3D2D1D0 || m_tkeep !== 4'hF || s_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: v=%b d=%h k=%h s_tready=%b", c, m_tvalid, m_tdata, m_tkeep, s_tready);
      end
    end
    @(posedge clk); #2;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'hE0 + 8'(i), 1'b0, w);
    flush();
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL stall_count: got %0d words want 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].data !== 32'hD3D2D1D0 || obs_q[1].data !== 32'hE3E2E1E0 ||
          obs_q[0].keep !== 4'hF || obs_q[1].keep !== 4'hF) begin
        n_fail++;
        $display("FAIL stall_words: got %h/%h want d3d2d1d0/e3e2e1e0", obs_q[0].data, obs_q[1].data);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int w;
    m_tready = 1'b0;
    send_beat(8'h77, 1'b1, w);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tkeep !== 4'h0) begin
      n_fail++; $display("FAIL rst_pending: got v=%b k=%h want 0/0", m_tvalid, m_tkeep);
    end
    @(posedge clk); #2; rst = 1'b0; m_tready = 1'b1;
    send_beat(8'h10, 1'b0, w);
    send_beat(8'h20, 1'b0, w);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got v=%b want 0", m_tvalid); end
    @(posedge clk); #2; rst = 1'b0;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) send_beat(8'hA1 + 8'(i), 1'b0, w);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hA4A3A2A1 || m_tkeep !== 4'hF) begin
      n_fail++; $display("FAIL rst_after: got v=%b d=%h k=%h want 1/a4a3a2a1/f", m_tvalid, m_tdata, m_tkeep);
    end
    flush();
    n_checks++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL rst_count: got %0d words want 1", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int  w;
    bit  done;
    bit  timed_out;
    logic [7:0] rb[$];
    bit         rl[$];
    done = 1'b0; timed_out = 1'b0;
    sent_b.delete(); sent_l.delete();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] d;
          bit l;
          if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2;
          end
          d = 8'($urandom);
          l = (i == 999) || ($urandom_range(0, 5) == 0);
          send_beat(d, l, w);
          if (w > 200) timed_out = 1'b1;
          sent_b.push_back(d); sent_l.push_back(l);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    flush();
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL rand_timeout: a beat waited >200 cycles"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_wordcount: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].keep !== exp_q[i].keep || obs_q[i].last !== exp_q[i].last) begin
          n_fail++;
          $display("FAIL rand_word%0d: got %h/%h/%b want %h/%h/%b", i, obs_q[i].data, obs_q[i].keep,
                   obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
    end
    foreach (obs_q[i]) begin
      int n;
      n = 0;
      for (int k = 0; k < 4; k++) if (obs_q[i].keep[k]) n = k + 1;
      for (int k = 0; k < n; k++) begin
        rb.push_back(obs_q[i].data[8*k +: 8]);
        rl.push_back(obs_q[i].last && (k == n - 1));
      end
    end
    n_checks++;
    if (rb.size() != sent_b.size()) begin
      n_fail++; $display("FAIL rand_bytecount: got %0d want %0d", rb.size(), sent_b.size());
    end else begin
      int bad;
      bad = 0;
      foreach (rb[i]) if (rb[i] !== sent_b[i] || rl[i] != sent_l[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rand_stream: %0d bytes differ, want 0", bad); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_words();
    test_early_last();
    test_single_beat();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
